// File: rtl/gps_pkg.sv
// Shared types and constants for the GPS frame sequencer and its helpers.
package gps_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        PUBLISH = 2'd3
    } gps_state_t;

    localparam int          GPS_PAYLOAD_LEN  = 4;
    localparam logic [7:0]  GPS_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/gps_byte_timeout.sv
// Inter-byte idle counter: expire fires on the enabled cycle that would count past LIMIT-1.
module gps_byte_timeout #(
    parameter int LIMIT = 1000,
    parameter int TO_W  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // A clear in the same cycle (byte accepted) always beats the threshold.
    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/gps_frame_sequencer.sv
// Hunts for a sync byte, collects a 4-byte position payload, verifies its XOR
// checksum and publishes latitude/longitude atomically with a one-cycle strobe.
module gps_frame_sequencer
    import gps_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = GPS_SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter int         TO_W           = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [15:0] latitude,
    output logic [15:0] longitude,
    output logic        fix_valid,
    output logic [7:0]  fix_count,
    output logic        err_checksum,
    output logic        err_timeout,
    output logic        busy
);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // the producer holds byte_data stable until then. byte_ready drops only in PUBLISH.

    localparam logic [1:0] LAST_IDX = 2'(GPS_PAYLOAD_LEN - 1);

    gps_state_t  state;
    logic [7:0]  payload_buf [GPS_PAYLOAD_LEN];
    logic [1:0]  idx;
    logic [7:0]  xor_acc;
    logic        accept;
    logic        in_frame;
    logic        to_clear;
    logic        to_expire;

    assign accept   = byte_valid && byte_ready;
    assign in_frame = (state == PAYLOAD) || (state == CHECK);
    assign to_clear = accept || !in_frame;

    gps_byte_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .TO_W  (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (to_clear),
        .enable (in_frame),
        .expire (to_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            xor_acc      <= '0;
            latitude     <= '0;
            longitude    <= '0;
            fix_count    <= '0;
            fix_valid    <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            busy         <= 1'b0;
            byte_ready   <= 1'b1;
            for (int i = 0; i < GPS_PAYLOAD_LEN; i++) begin
                payload_buf[i] <= '0;
            end
        end else begin
            fix_valid    <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && byte_data == SYNC_BYTE) begin
                        state   <= PAYLOAD;
                        idx     <= '0;
                        xor_acc <= '0;
                        busy    <= 1'b1;
                    end
                end

                PAYLOAD: begin
                    // A sync value here is plain data; no resynchronisation.
                    if (accept) begin
                        payload_buf[idx] <= byte_data;
                        xor_acc          <= xor_acc ^ byte_data;
                        idx              <= idx + 2'd1;
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end
                    end else if (to_expire) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end
                end

                CHECK: begin
                    if (accept) begin
                        if (byte_data == xor_acc) begin
                            state      <= PUBLISH;
                            byte_ready <= 1'b0;
                            latitude   <= {payload_buf[0], payload_buf[1]};
                            longitude  <= {payload_buf[2], payload_buf[3]};
                            fix_valid  <= 1'b1;
                            fix_count  <= fix_count + 8'd1;
                        end else begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            err_checksum <= 1'b1;
                        end
                    end else if (to_expire) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end
                end

                PUBLISH: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    byte_ready <= 1'b1;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    byte_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gps_frame_sequencer.sv
// Scenario bench for gps_frame_sequencer with a fix scoreboard and pulse counters.
module tb_gps_frame_sequencer;

    localparam int TO_CYC = 8;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [15:0] latitude;
    logic [15:0] longitude;
    logic        fix_valid;
    logic [7:0]  fix_count;
    logic        err_checksum;
    logic        err_timeout;
    logic        busy;

    gps_frame_sequencer #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_W           (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .latitude     (latitude),
        .longitude    (longitude),
        .fix_valid    (fix_valid),
        .fix_count    (fix_count),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard: {latitude, longitude, fix_count} per expected fix
    logic [39:0] exp_q[$];
    logic [7:0]  exp_count = 8'd0;
    int          exp_cks   = 0;
    int          exp_to    = 0;
    int          seen_cks  = 0;
    int          seen_to   = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (err_checksum) seen_cks++;
            if (err_timeout)  seen_to++;
            if (fix_valid || err_checksum || err_timeout) begin
                n_cmp++;
                if (int'(fix_valid) + int'(err_checksum) + int'(err_timeout) != 1) begin
                    n_err++;
                    $display("FAIL pulse_exclusive: fix=%b cks=%b to=%b want exactly one",
                             fix_valid, err_checksum, err_timeout);
                end
            end
            if (fix_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fix_unexpected: got lat=%h lon=%h cnt=%0d want no fix",
                             latitude, longitude, fix_count);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    if ({latitude, longitude, fix_count} !== e) begin
                        n_err++;
                        $display("FAIL fix_data: got %h want %h",
                                 {latitude, longitude, fix_count}, e);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = b;
            if (byte_ready) done = 1'b1;
            @(posedge clk);
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL byte_accept: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send_frame(input logic [31:0] pl, input logic [7:0] ck, input int max_gap);
        logic [7:0] x;
        x = pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
        if (ck == x) begin
            exp_count = exp_count + 8'd1;
            exp_q.push_back({pl, exp_count});
        end else begin
            exp_cks++;
        end
        send_byte(8'hA5);
        for (int i = 3; i >= 0; i--) begin
            if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
            send_byte(pl[i*8 +: 8]);
        end
        if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
        send_byte(ck);
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        rst        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // scenarios
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({latitude, longitude, fix_count} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_regs: got %h want 0", {latitude, longitude, fix_count});
        end
        n_cmp++;
        if ({fix_valid, err_checksum, err_timeout, busy, byte_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00001",
                     {fix_valid, err_checksum, err_timeout, busy, byte_ready});
        end
    endtask

    task automatic test_good_frame();
        send_frame(32'h12345678, 8'h08, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        n_cmp++;
        if ({fix_valid, latitude, longitude, fix_count, byte_ready} !== {1'b1, 16'h1234, 16'h5678, 8'd1, 1'b0}) begin
            n_err++;
            $display("FAIL good_latency: got v=%b lat=%h lon=%h cnt=%0d rdy=%b want 1 1234 5678 1 0",
                     fix_valid, latitude, longitude, fix_count, byte_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, fix_valid, byte_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL good_after: got busy/fix/rdy=%b want 001", {busy, fix_valid, byte_ready});
        end
    endtask

    task automatic test_bad_checksum();
        int c0;
        c0 = seen_cks;
        send_frame(32'h12345678, 8'h09, 0);
        idle_cycles(2);
        n_cmp++;
        if (seen_cks !== c0 + 1) begin
            n_err++;
            $display("FAIL bad_cks_pulse: got %0d pulses want 1", seen_cks - c0);
        end
        n_cmp++;
        if ({latitude, longitude, fix_count, busy} !== {16'h1234, 16'h5678, 8'd1, 1'b0}) begin
            n_err++;
            $display("FAIL bad_cks_hold: got lat=%h lon=%h cnt=%0d busy=%b want 1234 5678 1 0",
                     latitude, longitude, fix_count, busy);
        end
    endtask

    task automatic test_junk_sync();
        int e0;
        e0 = seen_cks + seen_to;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(32'h01020304, 8'h04, 0);
        idle_cycles(2);
        n_cmp++;
        if ({latitude, longitude, fix_count} !== {16'h0102, 16'h0304, 8'd2}) begin
            n_err++;
            $display("FAIL junk_fix: got lat=%h lon=%h cnt=%0d want 0102 0304 2",
                     latitude, longitude, fix_count);
        end
        n_cmp++;
        if (seen_cks + seen_to !== e0) begin
            n_err++;
            $display("FAIL junk_errors: got %0d error pulses want 0", seen_cks + seen_to - e0);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit hit;
        hit = 1'b0;
        n = 0;
        exp_to++;
        send_byte(8'hA5);
        send_byte(8'h11);
        @(negedge clk);
        byte_valid = 1'b0;
        for (int k = 1; k <= 40 && !hit; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (err_timeout) begin
                hit = 1'b1;
                n = k;
            end
        end
        n_cmp++;
        if (n !== TO_CYC) begin
            n_err++;
            $display("FAIL timeout_delay: got %0d cycles want %0d", n, TO_CYC);
        end
        n_cmp++;
        if ({busy, byte_ready, fix_count} !== {1'b0, 1'b1, 8'd2}) begin
            n_err++;
            $display("FAIL timeout_idle: got busy=%b rdy=%b cnt=%0d want 0 1 2", busy, byte_ready, fix_count);
        end
        send_frame(32'hCAFEBEEF, 8'hCA ^ 8'hFE ^ 8'hBE ^ 8'hEF, 0);
        idle_cycles(2);
        n_cmp++;
        if ({latitude, longitude} !== 32'hCAFEBEEF) begin
            n_err++;
            $display("FAIL timeout_recover: got %h want cafebeef", {latitude, longitude});
        end
    endtask

    task automatic test_sync_in_payload();
        send_frame(32'hA5000000, 8'hA5, 0);
        idle_cycles(2);
        n_cmp++;
        if ({latitude, longitude} !== 32'hA5000000) begin
            n_err++;
            $display("FAIL sync_payload: got %h want a5000000", {latitude, longitude});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        logic [7:0]  ck;
        send_frame(32'h11223344, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 0);
        send_frame(32'h55667788, 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88, 0);
        for (int f = 0; f < 14; f++) begin
            p  = $urandom;
            ck = p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
            if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
            send_frame(p, ck, (f < 7) ? 0 : 3);
        end
        idle_cycles(3);
        n_cmp++;
        if (fix_count !== exp_count) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want %0d", fix_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        e0 = seen_cks + seen_to;
        send_byte(8'hA5);
        send_byte(8'h21);
        send_byte(8'h43);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, byte_ready, fix_count, latitude} !== {1'b0, 1'b1, 8'd0, 16'h0}) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b rdy=%b cnt=%0d lat=%h want 0 1 0 0000",
                     busy, byte_ready, fix_count, latitude);
        end
        exp_count = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_frame(32'h0BADF00D, 8'h0B ^ 8'hAD ^ 8'hF0 ^ 8'h0D, 0);
        idle_cycles(3);
        n_cmp++;
        if ({latitude, longitude, fix_count} !== {32'h0BADF00D, 8'd1}) begin
            n_err++;
            $display("FAIL reset_recover: got %h want 0badf00d01", {latitude, longitude, fix_count});
        end
        n_cmp++;
        if (seen_cks + seen_to !== e0) begin
            n_err++;
            $display("FAIL reset_no_pulse: got %0d error pulses want 0", seen_cks + seen_to - e0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #2;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_junk_sync();
        test_timeout();
        test_sync_in_payload();
        test_back_to_back();
        test_reset_mid_frame();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fix_missing: got %0d fixes outstanding want 0", exp_q.size());
        end
        n_cmp++;
        if (seen_cks !== exp_cks || seen_to !== exp_to) begin
            n_err++;
            $display("FAIL err_totals: got cks=%0d to=%0d want cks=%0d to=%0d",
                     seen_cks, seen_to, exp_cks, exp_to);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
